// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the iterative RV32M multiplier.
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_t;

  // Two's-complement magnitude of a signed operand; unsigned operands pass
  // through. 0x80000000 maps to itself, read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    logic signed [XLEN-1:0] sv;
    sv = v;
    if (is_signed && (sv < 0)) begin
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end
    return v;
  endfunction

endpackage

// File: rtl/shift_expander.sv
// shift_expander: zero-extends a 32-bit operand to 64 bits and shifts it left
// by shift_index, giving the partial product for one multiplier bit.
module shift_expander (
  input  logic [31:0] input_a,
  input  logic [6:0]  shift_index,
  output logic [63:0] output_b
);

  // Pure combinational expand-and-shift.
  always_comb begin
    output_b = {32'b0, input_a} << shift_index;
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, one multiplier bit is accumulated per
// CALC cycle, and the sign is restored in FIX.
// Build option: define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining
// multiplier bits are all zero (latency 3 + msb_index(mag_b)); otherwise CALC
// always runs 32 cycles (fixed 34-cycle latency).
module seq_multiplier
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_t            state_q;
  mul_op_t               op_q;
  logic [XLEN-1:0]       mag_a_q;
  logic [XLEN-1:0]       mag_b_q;
  logic                  neg_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [4:0]            idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic [XLEN-1:0]       result_q;

  mul_op_t               op_d;
  logic                  a_signed_d;
  logic                  b_signed_d;
  logic [XLEN-1:0]       mag_a_d;
  logic [XLEN-1:0]       mag_b_d;
  logic                  neg_d;
  logic [2*XLEN-1:0]     shifted;
  logic [2*XLEN-1:0]     acc_add_d;
  logic [2*XLEN-1:0]     acc_fix_d;
  logic                  last_d;

  shift_expander u_shift_expander (
    .input_a     (mag_a_q),
    .shift_index ({2'b00, idx_q}),
    .output_b    (shifted)
  );

  // Operand conditioning at acceptance, accumulate step, sign fix and
  // CALC termination test.
  always_comb begin
    op_d       = mul_op_t'(op);
    a_signed_d = (op_d != MUL_OP_MULHU);
    b_signed_d = (op_d == MUL_OP_MUL) || (op_d == MUL_OP_MULH);
    mag_a_d    = magnitude(operand_a, a_signed_d);
    mag_b_d    = magnitude(operand_b, b_signed_d);
    neg_d      = (a_signed_d & operand_a[XLEN-1]) ^ (b_signed_d & operand_b[XLEN-1]);

    acc_add_d  = acc_q + (mag_b_q[idx_q] ? shifted : '0);
    acc_fix_d  = neg_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MUL_EARLY_EXIT_EN
    last_d     = (idx_q == 5'd31) || ((mag_b_q >> ({1'b0, idx_q} + 6'd1)) == '0);
`else
    last_d     = (idx_q == 5'd31);
`endif
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_add_d;
          idx_q <= idx_q + 5'd1;
          if (last_d) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          acc_q    <= acc_fix_d;
          result_q <= (op_q == MUL_OP_MUL) ? acc_fix_d[XLEN-1:0]
                                           : acc_fix_d[2*XLEN-1:XLEN];
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed bench for seq_multiplier; latency expectations
// follow the MUL_EARLY_EXIT_EN build option.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check busy/done every cycle up to the
  // first IDLE cycle after done. lat_ee is the early-exit latency.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat_ee, input int repulse);
    int   lat;
    logic eb;
`ifdef MUL_EARLY_EXIT_EN
    lat = lat_ee;
`else
    lat = 34;
`endif
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; operand_a = ~a; operand_b = ~b;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      eb = (cyc <= lat);
      check($sformatf("%s busy c%0d", tag, cyc), {31'b0, busy}, {31'b0, eb});
      eb = (cyc == lat);
      check($sformatf("%s done c%0d", tag, cyc), {31'b0, done}, {31'b0, eb});
      if (cyc >= lat) check($sformatf("%s result c%0d", tag, cyc), result, exp);
      if (repulse != 0 && cyc == repulse) begin
        start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (cyc <= lat) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);

    // Reset wins over start in the same cycle.
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst priority busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle busy", {31'b0, busy}, 32'd0);

    run_op("MUL 7x6",          2'b00, 32'd7,        32'd6,        32'h0000002A, 5,  0);
    run_op("MUL -1x-1",        2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3,  0);
    run_op("MULH -1x-1",       2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3,  0);
    run_op("MULHU max",        2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    run_op("MULHSU -1x2",      2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4,  0);
    run_op("MULH min x min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    run_op("MULH min x 1",     2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 3,  0);
    run_op("MUL 5x1",          2'b00, 32'd5,        32'd1,        32'h00000005, 3,  0);
    run_op("MUL 5xmin",        2'b00, 32'd5,        32'h80000000, 32'h80000000, 34, 0);
    run_op("MULHU repulse",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 10);

    // Reset in the middle of CALC discards the in-flight operation.
    op = 2'b11; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("midflight busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("abort no late done", {31'b0, done}, 32'd0);
    check("abort result held", result, 32'd0);

    run_op("MUL 3x5",          2'b00, 32'd3,        32'd5,        32'h0000000F, 5,  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-and-add multiplier for the core's RV32M multiply operations (MUL, MULH, MULHSU, MULHU). It sits directly downstream of `shift_expander`. It drives that block's `shift_index` and accumulates its 64-bit `output_b` into a product register, one multiplier bit per cycle. Results are returned to the execute stage through a start/done handshake.

## Interface
- `XLEN`, 32, operand width; only 32 is legal because `shift_expander` is fixed at 32→64.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start`  input  1  request pulse; sampled only in IDLE.
- `op`  input  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `operand_a`  input  32  multiplicand (rs1).
- `operand_b`  input  32  multiplier (rs2).
- `busy`  output  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  output  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  output  32  MUL: low word of the product; MULH/MULHSU/MULHU: high word.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - CALC: one multiplier bit per cycle.
  - FIX: applies the sign correction.
  - DONE: `done`=1, then returns to IDLE.
- Operand signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: `operand_a` signed, `operand_b` unsigned.
  - MULHU: both operands unsigned.
- On `start` in IDLE, the block latches the following:
  - `mag_a`/`mag_b`: two's-complement magnitudes of signed operands; unsigned operands pass through unchanged.
  - `neg` = XOR of the signs of the signed operands.
  - `op`.
  - Also: `acc`=0, `idx`=0.
- Magnitude of 0x80000000 is 0x80000000, interpreted as unsigned 32-bit; no overflow.
- CALC at index k:
  - `shift_expander` is fed `input_a`=`mag_a`, `shift_index`={2'b0,k}.
  - If `mag_b[k]`, then `acc` += `output_b` (64-bit, carry discarded; it cannot overflow).
  - `idx` increments each CALC cycle.
  - Exit to FIX after k=31.
- FIX: if `neg`, then `acc` = −`acc` (64-bit two's complement).
- DONE:
  - `result` = `acc[31:0]` for MUL, else `acc[63:32]`.
  - `result` is registered and holds until the next accepted `start`.
- `start` outside IDLE is ignored; operand and `op` changes after acceptance have no effect.
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, `acc`=0, `idx`=0.

## Timing
- `start` is sampled at edge T. CALC occupies cycles T+1..T+32 (idx 0..31), FIX is T+33, and DONE is T+34 (`done`=1, `busy`=1). The block is back in IDLE at T+35.
- Fixed latency is 34 cycles from acceptance to `done`.
- `start` asserted in the DONE cycle is ignored. `start` asserted in the first IDLE cycle after DONE is accepted, so back-to-back issue has a 35-cycle period.
- `rst_n` low at any edge, including mid-CALC, goes to IDLE next cycle with all outputs at reset values; the in-flight result is discarded.
- `rst_n` has priority over `start` in the same cycle.

## Configuration
- `MUL_EARLY_EXIT_EN` defined: at the end of CALC index k, the FSM goes to FIX if k==31 or `mag_b[31:k+1]`==0.
  - There is always at least one CALC cycle.
  - Latency = 3 + msb_index(`mag_b`) cycles; `mag_b` of 0 or 1 gives 3.
  - `result` is identical to the full-iteration result.
- Not defined: always 32 CALC cycles; fixed 34-cycle latency.

## Structure
- Package `mul_pkg` holds the following:
  - `XLEN` constant (32).
  - `mul_op_t` enum: `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU` = 2'b00..2'b11.
  - `mul_state_t` enum: IDLE, CALC, FIX, DONE.
- One sub-module instance: the existing `shift_expander`, driven combinationally from `mag_a` and `idx`. No new sub-modules.

## Test plan
- MUL, a=7, b=6 → `result`=0x0000002A; `done` at T+34 only; `busy` high T+1..T+34.
- MUL and MULH, a=b=0xFFFFFFFF (−1×−1) → MUL 0x00000001, MULH 0x00000000.
- MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=0x00000002 → 0xFFFFFFFF.
- MULH, a=b=0x80000000 → 0x40000000. MULH, a=0x80000000, b=0x00000001 → 0xFFFFFFFF.
- Robustness:
  - `start` re-pulsed at T+10 with different operands → ignored, original result returned.
  - `rst_n` low at T+15 → `busy`/`done`/`result`=0 next cycle.
  - A subsequent MUL 3×5 → 0x0000000F.
- With `MUL_EARLY_EXIT_EN`:
  - MUL 5×1 → 0x00000005, `done` at T+3.
  - MUL 5×0x80000000 → `done` at T+34, `result`=0x80000000.
